// File: rtl/sprite_arb_pkg.sv
// Shared types and default sizing for the sprite ROM read-port arbiter.
package sprite_arb_pkg;

   localparam int unsigned DEF_NUM_REQ  = 4;
   localparam int unsigned DEF_ADDR_W   = 10;
   localparam int unsigned DEF_DATA_W   = 2;
   localparam int unsigned DEF_LOCK_MAX = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARB    = 2'd1,
      LOCKED = 2'd2
   } arb_state_e;

   // Pointer width that stays legal for a single requester.
   function automatic int unsigned ptr_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Requester/ROM side bundle of the sprite ROM arbiter.
interface sprite_rom_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned DATA_W  = 2
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        req_lock;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]        gnt;
   logic [ADDR_W-1:0]         rom_addr;
   logic [DATA_W-1:0]         rom_q;
   logic [NUM_REQ-1:0]        rvalid;
   logic [DATA_W-1:0]         rdata;

   modport master (
      output req, req_lock, req_addr, rom_q,
      input  gnt, rom_addr, rvalid, rdata
   );

   modport slave (
      input  req, req_lock, req_addr, rom_q,
      output gnt, rom_addr, rvalid, rdata
   );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit at or above ptr, wrapping.
module rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt_c,
   output logic [PTR_W-1:0]   idx_c,
   output logic               vld_c
);

   always_comb begin
      int unsigned       k;
      logic [PTR_W-1:0]  k_idx;
      gnt_c = '0;
      idx_c = '0;
      vld_c = 1'b0;
      k     = 0;
      k_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         k = 32'(ptr) + i;
         if (k >= NUM_REQ) k = k - NUM_REQ;
         k_idx = PTR_W'(k);
         if (!vld_c && req[k_idx]) begin
            vld_c        = 1'b1;
            gnt_c[k_idx] = 1'b1;
            idx_c        = k_idx;
         end
      end
   end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM read port among NUM_REQ requesters.
// Define SPRITE_ARB_LOCK_EN to enable burst-lock (owner held for up to LOCK_MAX grants).
module sprite_rom_arbiter
   import sprite_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned LOCK_MAX = DEF_LOCK_MAX
) (
   input logic                 vga_clk,
   input logic                 reset_n,
   sprite_rom_arbiter_if.slave bus
);

   localparam int unsigned PTR_W = ptr_w(NUM_REQ);

   arb_state_e         state_q, state_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0] rvalid_q;
   logic [NUM_REQ-1:0] gnt_c;
   logic [PTR_W-1:0]   gnt_idx_c;
   logic               gnt_vld_c;
   logic               arb_en_c;
   logic [NUM_REQ-1:0] pick_gnt;
   logic [PTR_W-1:0]   pick_idx;
   logic               pick_vld;

`ifdef SPRITE_ARB_LOCK_EN
   localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
   logic [PTR_W-1:0] owner_q, owner_d;
   logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
`else
   logic unused_lock;
   assign unused_lock = ^{bus.req_lock, 32'(LOCK_MAX)};
`endif

   rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr_pick (
      .req   (bus.req),
      .ptr   (rr_ptr_q),
      .gnt_c (pick_gnt),
      .idx_c (pick_idx),
      .vld_c (pick_vld)
   );

   // Next state, pointer and grant; a lock that cannot hold re-arbitrates in the same cycle.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      gnt_c     = '0;
      gnt_idx_c = '0;
      gnt_vld_c = 1'b0;
      arb_en_c  = 1'b1;
`ifdef SPRITE_ARB_LOCK_EN
      owner_d    = owner_q;
      lock_cnt_d = lock_cnt_q;
`endif
      case (state_q)
         LOCKED: begin
`ifdef SPRITE_ARB_LOCK_EN
            if (bus.req[owner_q] && bus.req_lock[owner_q] &&
                (lock_cnt_q < CNT_W'(LOCK_MAX))) begin
               arb_en_c         = 1'b0;
               gnt_c[owner_q]   = 1'b1;
               gnt_idx_c        = owner_q;
               gnt_vld_c        = 1'b1;
               lock_cnt_d       = lock_cnt_q + CNT_W'(1);
            end
`endif
         end
         default: ;
      endcase

      if (arb_en_c) begin
         if (pick_vld) begin
            gnt_c     = pick_gnt;
            gnt_idx_c = pick_idx;
            gnt_vld_c = 1'b1;
            rr_ptr_d  = (32'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + PTR_W'(1);
            state_d   = ARB;
`ifdef SPRITE_ARB_LOCK_EN
            lock_cnt_d = '0;
            if (bus.req_lock[pick_idx]) begin
               state_d    = LOCKED;
               owner_d    = pick_idx;
               lock_cnt_d = CNT_W'(1);
            end
`endif
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         rvalid_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         rvalid_q <= gnt_c;
      end
   end

`ifdef SPRITE_ARB_LOCK_EN
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         owner_q    <= '0;
         lock_cnt_q <= '0;
      end else begin
         owner_q    <= owner_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end
`endif

   // Grant path is combinational, so reset must gate it directly.
   assign bus.gnt      = reset_n ? gnt_c : '0;
   assign bus.rom_addr = (reset_n && gnt_vld_c) ?
                         bus.req_addr[32'(gnt_idx_c)*ADDR_W +: ADDR_W] : '0;
   assign bus.rvalid   = rvalid_q;
   assign bus.rdata    = (|rvalid_q) ? bus.rom_q : '0;

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one sprite ROM read port.
REQ-002 Parameter ADDR_W, default 10: ROM address width (32x32 sprite).
REQ-003 Parameter DATA_W, default 2: ROM palette-index width.
REQ-004 Parameter LOCK_MAX, default 32: maximum consecutive grants under lock (one sprite row).
REQ-005 vga_clk  input  1  sole clock; all state updates on posedge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 req  input  NUM_REQ  per-requester read request, level.
REQ-008 req_lock  input  NUM_REQ  per-requester burst-lock hint, sampled only with req.
REQ-009 req_addr  input  NUM_REQ*ADDR_W  packed addresses; slice i belongs to requester i.
REQ-010 gnt  output  NUM_REQ  one-hot grant, same cycle as accepted request.
REQ-011 rom_addr  output  ADDR_W  address driven to the ROM.
REQ-012 rom_q  input  DATA_W  ROM data, valid one posedge after rom_addr.
REQ-013 rvalid  output  NUM_REQ  one-hot read-return strobe.
REQ-014 rdata  output  DATA_W  returned palette index, qualified by rvalid.

Function
REQ-015 gnt shall be combinational from req, state and pointer; at most one bit set; gnt[i] only if req[i].
REQ-016 rom_addr shall equal req_addr slice of the granted requester; 0 when no grant.
REQ-017 Read latency shall be exactly 1 cycle: grant at cycle t -> rvalid[i]=1 and rdata=rom_q at cycle t+1.
REQ-018 A requester granted on consecutive cycles shall receive rvalid on each following cycle; no return dropped or reordered.
REQ-019 FSM states: IDLE (no req), ARB (round-robin), LOCKED (owner held).
REQ-020 IDLE->ARB when any req; ARB->IDLE when none; ARB grants the first req[i] at or after rr_ptr, scanning upward with wrap NUM_REQ-1 -> 0.
REQ-021 After each grant in ARB, rr_ptr shall become (granted index + 1) mod NUM_REQ.
REQ-022 Simultaneous requests shall each be granted within NUM_REQ cycles (no starvation in ARB).
REQ-023 Requests arriving mid-cycle shall be considered the same cycle; a dropped req never receives gnt.

Reset
REQ-024 On reset_n low: gnt=0, rvalid=0, rdata=0, rom_addr=0, rr_ptr=0, lock_cnt=0, state=IDLE, immediately and asynchronously.
REQ-025 A return pending at reset assertion shall be discarded; no rvalid after reset release without a new grant.
REQ-026 First grant after reset release with all req high shall go to requester 0.

Configuration
REQ-027 Macro SPRITE_ARB_LOCK_EN: when defined, grant with req_lock[i]=1 in ARB enters LOCKED with owner i and lock_cnt=1.
REQ-028 In LOCKED, owner is granted while req[i]&req_lock[i] and lock_cnt<LOCK_MAX, lock_cnt incrementing; other requesters stall.
REQ-029 LOCKED exits to ARB (rr_ptr=owner+1) when owner drops req or req_lock, or when lock_cnt reaches LOCK_MAX (forced release, same cycle re-arbitration excludes owner priority).
REQ-030 Without SPRITE_ARB_LOCK_EN: req_lock ignored, LOCKED unreachable, lock_cnt not implemented.

Structure
REQ-031 Package sprite_arb_pkg shall hold state enum (IDLE, ARB, LOCKED) and default ADDR_W, DATA_W, LOCK_MAX constants.
REQ-032 Sub-module rr_pick (combinational round-robin one-hot selector from req vector and pointer) shall be instantiated once.

Verification
REQ-033 Reset release, req=4'b1111 held -> gnt sequence 0001,0010,0100,1000,0001; rvalid same sequence delayed 1 cycle.
REQ-034 req=4'b0100, req_addr[2]=10'h3FF, rom model returns 2'b11 -> rom_addr=3FF at t, rvalid=0100, rdata=11 at t+1.
REQ-035 rr_ptr=3, req=4'b1001 -> gnt=1000, then gnt=0001 (wrap).
REQ-036 LOCK_EN, req=4'b0011 with req_lock[0]=1 held -> gnt=0001 for 32 cycles, then 0010 on cycle 33.
REQ-037 Grant at cycle t, reset_n low between t and t+1 -> rvalid stays 0 after release; outputs zero during reset.
REQ-038 Without LOCK_EN, same stimulus as REQ-036 -> gnt alternates 0001,0010.
